// File: rtl/sbox_responder.sv
// sbox_responder: byte-serial AES S-box responder using arithmetic GF(2^8) inversion.
// Define SBOX_INV_EN to add the decrypt_in port and the inverse S-box path.
module sbox_responder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       addr_in,
    input  logic             ce,
    input  logic             re,
`ifdef SBOX_INV_EN
    input  logic             decrypt_in,
`endif
    input  logic             clr_cnt,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] acc_cnt
);

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); a zero input yields zero, as required
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b
            ^ {b[6:0], b[7]}
            ^ {b[5:0], b[7:6]}
            ^ {b[4:0], b[7:5]}
            ^ {b[3:0], b[7:4]}
            ^ 8'h63;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]}
            ^ {b[4:0], b[7:5]}
            ^ {b[1:0], b[7:2]}
            ^ 8'h05;
    endfunction
`endif

    logic       accept;
    logic [7:0] result;

    assign accept = !ce && !re;

`ifdef SBOX_INV_EN
    logic [7:0] inv_in;
    logic [7:0] inv_out;

    always_comb begin
        inv_in  = decrypt_in ? inv_affine(addr_in) : addr_in;
        inv_out = gf_inv(inv_in);
        result  = decrypt_in ? inv_out : affine(inv_out);
    end
`else
    always_comb begin
        result = affine(gf_inv(addr_in));
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            valid_out <= accept;
            if (accept) data_out <= result;
        end
    end

    // clear wins over a same-cycle increment; count sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= '0;
        end else if (clr_cnt) begin
            acc_cnt <= '0;
        end else if (accept && !(&acc_cnt)) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sbox_responder.sv
// tb_sbox_responder: randomized scoreboard bench for sbox_responder.
// Builds its S-box tables by brute-force GF(2^8) inversion at time zero.
module tb_sbox_responder;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [7:0]    addr;
    logic          ce;
    logic          re;
    logic          dec;
    logic          clr;
    logic [7:0]    data_out;
    logic          valid_out;
    logic [CW-1:0] acc_cnt;

    int errors = 0;
    int checks = 0;

    int sbox_tab [256];
    int inv_tab  [256];
    int q [$];

    int exp_data  = 0;
    int exp_valid = 0;
    int exp_cnt   = 0;

    int burst_exp [16] = '{
        'h63, 'h7C, 'h77, 'h7B, 'hF2, 'h6B, 'h6F, 'hC5,
        'h30, 'h01, 'h67, 'h2B, 'hFE, 'hD7, 'hAB, 'h76
    };

    sbox_responder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .addr_in   (addr),
        .ce        (ce),
        .re        (re),
`ifdef SBOX_INV_EN
        .decrypt_in(dec),
`endif
        .clr_cnt   (clr),
        .data_out  (data_out),
        .valid_out (valid_out),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // polynomial product, then long-division reduction by 0x11B
    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int k = 14; k >= 8; k--)
            if (((p >> k) & 1) != 0) p = p ^ ('h11B << (k - 8));
        return p;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 'hFF;
    endfunction

    function automatic int model(input int a, input int d);
        return (d != 0) ? inv_tab[a] : sbox_tab[a];
    endfunction

    task automatic build_tables();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(x, y) == 1) inv = y;
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 'h63;
            sbox_tab[x] = s;
            inv_tab[s]  = x;
        end
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // reference state advanced from the driven inputs at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data  = 0;
            exp_valid = 0;
            exp_cnt   = 0;
            q.delete();
        end else begin
            if (!ce && !re) begin
                exp_data  = model(int'(addr), int'(dec));
                exp_valid = 1;
            end else begin
                exp_valid = 0;
            end
            if (clr) exp_cnt = 0;
            else if (!ce && !re && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
        end
    end

    always @(negedge clk) begin
        int e;
        chk("valid", int'(valid_out), exp_valid);
        chk("hold_data", int'(data_out), exp_data);
        chk("acc_cnt", int'(acc_cnt), exp_cnt);
        if (valid_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h want no result", data_out);
            end else begin
                e = q.pop_front();
                chk("result", int'(data_out), e);
            end
        end
    end

    task automatic step(
        input logic       c,
        input logic       r,
        input logic [7:0] a,
        input logic       d,
        input logic       cl,
        input int         want
    );
        @(posedge clk);
        #1;
        ce   = c;
        re   = r;
        addr = a;
        dec  = d;
        clr  = cl;
        if (!c && !r && rst_n)
            q.push_back(want < 0 ? model(int'(a), int'(d)) : want);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, -1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        ce  = 1'b1;
        re  = 1'b1;
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic c;
        logic r;
        logic d;
        rst_n = 1'b1;
        ce    = 1'b1;
        re    = 1'b1;
        addr  = 8'h00;
        dec   = 1'b0;
        clr   = 1'b0;
        build_tables();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_cnt", int'(acc_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) idle();
        @(negedge clk);
        chk("post_rst_valid", int'(valid_out), 0);
        chk("post_rst_data", int'(data_out), 0);

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 'h63);
        idle();
        step(1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 'h7C);
        idle();
        step(1'b0, 1'b0, 8'h53, 1'b0, 1'b0, 'hED);
        idle();
        step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 'h16);
        settle();
        chk("single_ff", int'(data_out), 'h16);
        chk("single_valid", int'(valid_out), 1);
        @(negedge clk);
        chk("single_hold", int'(data_out), 'h16);
        chk("single_drop", int'(valid_out), 0);

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 8'(i), 1'b0, 1'b0, burst_exp[i]);
        settle();
        chk("burst_last", int'(data_out), 'h76);

        step(1'b0, 1'b1, 8'h53, 1'b0, 1'b0, -1);
        step(1'b1, 1'b0, 8'h53, 1'b0, 1'b0, -1);
        settle();
        chk("strobe_valid", int'(valid_out), 0);
        chk("strobe_hold", int'(data_out), 'h76);

        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, -1);
        settle();
        chk("clr_only", int'(acc_cnt), 0);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, -1);
        settle();
        chk("cnt_sat", int'(acc_cnt), CMAX);
        step(1'b0, 1'b0, 8'h53, 1'b0, 1'b1, 'hED);
        settle();
        chk("clr_read_cnt", int'(acc_cnt), 0);
        chk("clr_read_data", int'(data_out), 'hED);
        chk("clr_read_valid", int'(valid_out), 1);

        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, -1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", int'(valid_out), 0);
        chk("mid_rst_data", int'(data_out), 0);
        chk("mid_rst_cnt", int'(acc_cnt), 0);
        step(1'b0, 1'b0, 8'h42, 1'b0, 1'b0, -1);
        @(posedge clk);
        #1;
        ce = 1'b1;
        re = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) idle();
        @(negedge clk);
        chk("after_rst_valid", int'(valid_out), 0);

`ifdef SBOX_INV_EN
        step(1'b0, 1'b0, 8'h63, 1'b1, 1'b0, 'h00);
        step(1'b0, 1'b0, 8'hED, 1'b1, 1'b0, 'h53);
        step(1'b0, 1'b0, 8'h16, 1'b1, 1'b0, 'hFF);
        for (int x = 0; x < 256; x++) begin
            step(1'b0, 1'b0, 8'(x), 1'b0, 1'b0, -1);
            step(1'b0, 1'b0, 8'(sbox_tab[x]), 1'b1, 1'b0, x);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
`ifdef SBOX_INV_EN
            d = 1'($urandom);
`else
            d = 1'b0;
`endif
            step(c, r, 8'($urandom), d, ($urandom_range(0, 15) == 0), -1);
        end

        repeat (4) idle();
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
